// File: rtl/router_cc_pkg.sv
// rtl/router_cc_pkg.sv - shared constants, port indices, input FSM states and routing helpers for router_cc
package router_cc_pkg;

    localparam int TAM_FLIT   = 16;
    localparam int METADEFLIT = TAM_FLIT / 2;
    localparam int TAM_BUFFER = 4;
    localparam int NPORT      = 5;
    localparam int NUM_X      = 4;
    localparam int NUM_Y      = 4;
    localparam int NROT       = NUM_X * NUM_Y;

    localparam int PORT_W = 3;
    localparam int PTR_W  = $clog2(TAM_BUFFER);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [PORT_W-1:0] EAST  = 3'd0;
    localparam logic [PORT_W-1:0] WEST  = 3'd1;
    localparam logic [PORT_W-1:0] NORTH = 3'd2;
    localparam logic [PORT_W-1:0] SOUTH = 3'd3;
    localparam logic [PORT_W-1:0] LOCAL = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_SEND
    } in_state_t;

    // X is resolved completely before Y, which keeps the mesh deadlock-free.
    function automatic logic [PORT_W-1:0] xy_route(input logic [TAM_FLIT-1:0] target,
                                                   input logic [TAM_FLIT-1:0] own);
        logic [METADEFLIT-1:0] tgt_x, tgt_y, own_x, own_y;
        tgt_x = target[TAM_FLIT-1:METADEFLIT];
        tgt_y = target[METADEFLIT-1:0];
        own_x = own[TAM_FLIT-1:METADEFLIT];
        own_y = own[METADEFLIT-1:0];
        if (tgt_x > own_x)      return EAST;
        else if (tgt_x < own_x) return WEST;
        else if (tgt_y > own_y) return NORTH;
        else if (tgt_y < own_y) return SOUTH;
        else                    return LOCAL;
    endfunction

    function automatic logic [PORT_W-1:0] rr_next(input logic [PORT_W-1:0] p);
        return (p == PORT_W'(NPORT - 1)) ? '0 : p + PORT_W'(1);
    endfunction

endpackage

// File: rtl/router_input_buffer.sv
// rtl/router_input_buffer.sv - per-port input FIFO with packet FSM and flit counter
module router_input_buffer
    import router_cc_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                rx,
    input  logic [TAM_FLIT-1:0] data_in,
    input  logic                pop,
    input  logic                grant,
    output logic                credit_o,
    output logic                empty,
    output logic [TAM_FLIT-1:0] head,
    output logic                req,
    output logic                last
);

    logic [TAM_FLIT-1:0] mem [TAM_BUFFER];
    logic [PTR_W-1:0]    rd_ptr, wr_ptr;
    logic [CNT_W-1:0]    count, count_next;
    logic                push;
    in_state_t           state, state_next;
    logic [TAM_FLIT-1:0] cnt, cnt_next;

    assign push  = rx && credit_o;
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CNT_W'(1);
        else if (!push && pop)
            count_next = count - CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= data_in;
    end

    // credit_o is the registered not-full flag, so a push is never offered into a full FIFO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            credit_o <= 1'b1;
            state    <= S_IDLE;
            cnt      <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count    <= count_next;
            credit_o <= (count_next != CNT_W'(TAM_BUFFER));
            state    <= state_next;
            cnt      <= cnt_next;
        end
    end

    // cnt holds 2 until the size flit is at the head, then the remaining payload count.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        req        = 1'b0;
        last       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty)
                    state_next = S_REQ;
            end
            S_REQ: begin
                req = 1'b1;
                if (grant) begin
                    state_next = S_WAIT;
                    cnt_next   = TAM_FLIT'(2);
                end
            end
            S_WAIT: begin
                if (pop) begin
                    if (cnt == TAM_FLIT'(2)) begin
                        cnt_next = TAM_FLIT'(1);
                    end else if (head == '0) begin
                        last       = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        cnt_next   = head;
                        state_next = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (pop) begin
                    cnt_next = cnt - TAM_FLIT'(1);
                    if (cnt == TAM_FLIT'(1)) begin
                        last       = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: rtl/router_cc.sv
// rtl/router_cc.sv - five-port XY mesh router with round-robin switch control and credit flow control
module router_cc
    import router_cc_pkg::*;
#(
    parameter logic [TAM_FLIT-1:0] address = 16'h0000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NPORT-1:0]          credit_i,
    input  logic [NPORT-1:0]          clock_rx,
    input  logic [NPORT-1:0]          rx,
    input  logic [NPORT*TAM_FLIT-1:0] data_in,
    output logic [NPORT-1:0]          credit_o,
    output logic [NPORT-1:0]          clock_tx,
    output logic [NPORT-1:0]          tx,
    output logic [NPORT*TAM_FLIT-1:0] data_out
);

    logic [NPORT-1:0]    buf_empty, req, last, pop, grant, xfer;
    logic [TAM_FLIT-1:0] head [NPORT];

    logic [NPORT-1:0]    out_busy;
    logic [PORT_W-1:0]   out_src [NPORT];
    logic [PORT_W-1:0]   rr_ptr;

    logic                sel_valid, grant_ok;
    logic [PORT_W-1:0]   sel_port, sel_out, cand;

    logic                unused_clock_rx;

    assign unused_clock_rx = ^clock_rx;
    assign clock_tx        = {NPORT{clock}};

    for (genvar p = 0; p < NPORT; p++) begin : g_in
        router_input_buffer u_buf (
            .clock    (clock),
            .reset    (reset),
            .rx       (rx[p]),
            .data_in  (data_in[p*TAM_FLIT +: TAM_FLIT]),
            .pop      (pop[p]),
            .grant    (grant[p]),
            .credit_o (credit_o[p]),
            .empty    (buf_empty[p]),
            .head     (head[p]),
            .req      (req[p]),
            .last     (last[p])
        );
    end

    // One request per cycle; a request whose output is busy is skipped and retried later.
    always_comb begin
        sel_valid = 1'b0;
        sel_port  = '0;
        cand      = rr_next(rr_ptr);
        for (int k = 0; k < NPORT; k++) begin
            if (!sel_valid && req[cand]) begin
                sel_valid = 1'b1;
                sel_port  = cand;
            end
            cand = rr_next(cand);
        end
        sel_out  = xy_route(head[sel_port], address);
        grant_ok = sel_valid && !out_busy[sel_out];
        grant    = '0;
        if (grant_ok)
            grant[sel_port] = 1'b1;
    end

    always_comb begin
        tx       = '0;
        data_out = '0;
        xfer     = '0;
        pop      = '0;
        for (int o = 0; o < NPORT; o++) begin
            if (out_busy[o]) begin
                tx[o]                               = !buf_empty[out_src[o]];
                data_out[o*TAM_FLIT +: TAM_FLIT]    = head[out_src[o]];
                xfer[o]                             = tx[o] && credit_i[o];
                if (xfer[o])
                    pop[out_src[o]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_busy <= '0;
            rr_ptr   <= EAST;
            for (int o = 0; o < NPORT; o++)
                out_src[o] <= '0;
        end else begin
            if (sel_valid)
                rr_ptr <= sel_port;
            for (int o = 0; o < NPORT; o++) begin
                if (xfer[o] && last[out_src[o]])
                    out_busy[o] <= 1'b0;
            end
            if (grant_ok) begin
                out_busy[sel_out] <= 1'b1;
                out_src[sel_out]  <= sel_port;
            end
        end
    end

endmodule

// File: tb/tb_router_cc.sv
// tb/tb_router_cc.sv - self-checking bench for router_cc
module tb_router_cc;

    localparam int NP = 5;
    localparam int FW = 16;
    localparam int PE = 0;
    localparam int PW = 1;
    localparam int PN = 2;
    localparam int PS = 3;
    localparam int PL = 4;
    localparam logic [15:0] ADDR = 16'h0101;

    logic             clock = 1'b0;
    logic             reset;
    logic [NP-1:0]    credit_i, clock_rx, rx, credit_o, clock_tx, tx;
    logic [NP*FW-1:0] data_in, data_out;

    router_cc #(.address(ADDR)) dut (
        .clock    (clock),
        .reset    (reset),
        .credit_i (credit_i),
        .clock_rx (clock_rx),
        .rx       (rx),
        .data_in  (data_in),
        .credit_o (credit_o),
        .clock_tx (clock_tx),
        .tx       (tx),
        .data_out (data_out)
    );

    always #5 clock = ~clock;
    assign clock_rx = {NP{clock}};

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] in_q  [NP][$];
    logic [15:0] obs_q [NP][$];
    logic [15:0] exp_q [NP][NP][$];
    int          base  [NP];

    always @(negedge clock) begin
        for (int o = 0; o < NP; o++)
            if (tx[o] && credit_i[o])
                obs_q[o].push_back(data_out[o*FW +: FW]);
    end

    function automatic int route_ref(input logic [15:0] h);
        int tgt_x, tgt_y, own_x, own_y;
        tgt_x = int'(h) / 256;
        tgt_y = int'(h) % 256;
        own_x = int'(ADDR) / 256;
        own_y = int'(ADDR) % 256;
        if (tgt_x != own_x) return (tgt_x > own_x) ? PE : PW;
        if (tgt_y != own_y) return (tgt_y > own_y) ? PN : PS;
        return PL;
    endfunction

    function automatic int olen(input int o);
        return obs_q[o].size() - base[o];
    endfunction

    task automatic mark();
        for (int o = 0; o < NP; o++) base[o] = obs_q[o].size();
    endtask

    task automatic step();
        logic [NP-1:0] acc;
        for (int p = 0; p < NP; p++) begin
            rx[p] = (in_q[p].size() != 0);
            data_in[p*FW +: FW] = rx[p] ? in_q[p][0] : 16'h0000;
        end
        @(negedge clock);
        acc = rx & credit_o;
        @(posedge clock);
        #1;
        for (int p = 0; p < NP; p++)
            if (acc[p]) void'(in_q[p].pop_front());
        rx = '0;
    endtask

    task automatic run_idle(input int n);
        repeat (n) step();
    endtask

    task automatic apply_reset();
        reset    = 1'b0;
        rx       = '0;
        data_in  = '0;
        credit_i = '1;
        for (int p = 0; p < NP; p++) in_q[p].delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        vectors++;
        if (tx !== 5'b00000) begin miscompares++; $display("FAIL rst_tx got %b want 00000", tx); end
        vectors++;
        if (data_out !== '0) begin miscompares++; $display("FAIL rst_data got %h want 0", data_out); end
        vectors++;
        if (credit_o !== 5'b11111) begin miscompares++; $display("FAIL rst_credit got %b want 11111", credit_o); end
        vectors++;
        if (clock_tx !== {NP{clock}}) begin miscompares++; $display("FAIL rst_clock_tx_hi got %b want %b", clock_tx, {NP{clock}}); end
        @(negedge clock);
        #1;
        vectors++;
        if (clock_tx !== 5'b00000) begin miscompares++; $display("FAIL rst_clock_tx_lo got %b want 00000", clock_tx); end
        @(posedge clock);
        #1;
        reset = 1'b1;
        run_idle(2);
        vectors++;
        if (tx !== 5'b00000 || credit_o !== 5'b11111) begin
            miscompares++; $display("FAIL rst_release got tx=%b credit=%b want 00000/11111", tx, credit_o);
        end
    endtask

    task automatic test_single();
        logic [15:0] exp [4];
        exp = '{16'h0201, 16'h0002, 16'hAAAA, 16'hBBBB};
        mark();
        for (int i = 0; i < 4; i++) in_q[PL].push_back(exp[i]);
        step();
        vectors++;
        if (tx !== 5'b00000) begin miscompares++; $display("FAIL single_lat_k got %b want 00000", tx); end
        step();
        vectors++;
        if (tx !== 5'b00000) begin miscompares++; $display("FAIL single_lat_k1 got %b want 00000", tx); end
        step();
        vectors++;
        if (tx !== 5'b00001 || data_out[PE*FW +: FW] !== 16'h0201) begin
            miscompares++; $display("FAIL single_lat_k2 got tx=%b data=%h want 00001/0201", tx, data_out[PE*FW +: FW]);
        end
        run_idle(10);
        vectors++;
        if (olen(PE) != 4 || olen(PW) + olen(PN) + olen(PS) + olen(PL) != 0) begin
            miscompares++; $display("FAIL single_count got east=%0d others=%0d want 4/0", olen(PE), olen(PW) + olen(PN) + olen(PS) + olen(PL));
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (obs_q[PE][base[PE]+i] !== exp[i]) begin
                    miscompares++; $display("FAIL single_flit%0d got %h want %h", i, obs_q[PE][base[PE]+i], exp[i]);
                end
            end
        end
        vectors++;
        if (tx !== 5'b00000) begin miscompares++; $display("FAIL single_freed got %b want 00000", tx); end
    endtask

    task automatic test_routing();
        logic [15:0] hdr [4];
        int          dst [4];
        int          src, others;
        hdr = '{16'h0102, 16'h0100, 16'h0001, 16'h0101};
        dst = '{PN, PS, PW, PL};
        for (int t = 0; t < 4; t++) begin
            mark();
            src = $urandom_range(0, NP - 1);
            in_q[src].push_back(hdr[t]);
            in_q[src].push_back(16'h0000);
            run_idle(12);
            others = 0;
            for (int o = 0; o < NP; o++) if (o != dst[t]) others += olen(o);
            vectors++;
            if (olen(dst[t]) != 2 || others != 0) begin
                miscompares++; $display("FAIL route_%h got dst_flits=%0d others=%0d want 2/0", hdr[t], olen(dst[t]), others);
            end else begin
                vectors++;
                if (obs_q[dst[t]][base[dst[t]]] !== hdr[t] || obs_q[dst[t]][base[dst[t]]+1] !== 16'h0000) begin
                    miscompares++; $display("FAIL route_%h_flits got %h %h want %h 0000", hdr[t],
                                            obs_q[dst[t]][base[dst[t]]], obs_q[dst[t]][base[dst[t]]+1], hdr[t]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp [6];
        exp = '{16'h0201, 16'h0004, 16'hC001, 16'hC002, 16'hC003, 16'hC004};
        mark();
        credit_i = 5'b11110;
        for (int i = 0; i < 6; i++) in_q[PL].push_back(exp[i]);
        run_idle(6);
        vectors++;
        if (in_q[PL].size() != 2 || credit_o[PL] !== 1'b0) begin
            miscompares++; $display("FAIL bp_full got accepted=%0d credit=%b want 4/0", 6 - in_q[PL].size(), credit_o[PL]);
        end
        vectors++;
        if (tx[PE] !== 1'b1 || olen(PE) != 0) begin
            miscompares++; $display("FAIL bp_hold got tx=%b sent=%0d want 1/0", tx[PE], olen(PE));
        end
        credit_i = '1;
        run_idle(20);
        vectors++;
        if (olen(PE) != 6) begin
            miscompares++; $display("FAIL bp_count got %0d want 6", olen(PE));
        end else begin
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (obs_q[PE][base[PE]+i] !== exp[i]) begin
                    miscompares++; $display("FAIL bp_flit%0d got %h want %h", i, obs_q[PE][base[PE]+i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_contention();
        logic [15:0] pw_pkt [5];
        logic [15:0] ps_pkt [5];
        pw_pkt = '{16'h0201, 16'h0003, 16'hA001, 16'hA002, 16'hA003};
        ps_pkt = '{16'h0201, 16'h0003, 16'hB001, 16'hB002, 16'hB003};
        apply_reset();
        mark();
        for (int i = 0; i < 5; i++) begin
            in_q[PW].push_back(pw_pkt[i]);
            in_q[PS].push_back(ps_pkt[i]);
        end
        run_idle(30);
        vectors++;
        if (olen(PE) != 10) begin
            miscompares++; $display("FAIL contend_count got %0d want 10", olen(PE));
        end else begin
            for (int i = 0; i < 10; i++) begin
                vectors++;
                if (obs_q[PE][base[PE]+i] !== ((i < 5) ? pw_pkt[i] : ps_pkt[i-5])) begin
                    miscompares++; $display("FAIL contend_flit%0d got %h want %h", i, obs_q[PE][base[PE]+i],
                                            (i < 5) ? pw_pkt[i] : ps_pkt[i-5]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        mark();
        in_q[PL].push_back(16'h0201);
        in_q[PL].push_back(16'h0004);
        for (int i = 0; i < 4; i++) in_q[PL].push_back(16'hD000 + 16'(i));
        cyc = 0;
        while (olen(PE) < 2 && cyc < 20) begin
            step();
            cyc++;
        end
        vectors++;
        if (olen(PE) < 2) begin miscompares++; $display("FAIL midrst_timeout got %0d flits want 2", olen(PE)); end
        reset = 1'b0;
        #1;
        vectors++;
        if (tx !== 5'b00000 || data_out !== '0 || credit_o !== 5'b11111) begin
            miscompares++; $display("FAIL midrst_flush got tx=%b credit=%b want 00000/11111", tx, credit_o);
        end
        apply_reset();
        mark();
        in_q[PL].push_back(16'h0102);
        in_q[PL].push_back(16'h0001);
        in_q[PL].push_back(16'h5A5A);
        run_idle(12);
        vectors++;
        if (olen(PN) != 3 || olen(PE) != 0) begin
            miscompares++; $display("FAIL midrst_fresh got north=%0d east=%0d want 3/0", olen(PN), olen(PE));
        end else begin
            vectors++;
            if (obs_q[PN][base[PN]] !== 16'h0102 || obs_q[PN][base[PN]+1] !== 16'h0001 || obs_q[PN][base[PN]+2] !== 16'h5A5A) begin
                miscompares++; $display("FAIL midrst_flits got %h %h %h want 0102 0001 5a5a",
                                        obs_q[PN][base[PN]], obs_q[PN][base[PN]+1], obs_q[PN][base[PN]+2]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] h, pl;
        int          n, o, cyc, idx, len, pending;
        bit          found, ok;
        for (int p = 0; p < NP; p++) begin
            for (int k = 0; k < 3; k++) begin
                h = {8'($urandom_range(0, 2)), 8'($urandom_range(0, 2))};
                n = $urandom_range(0, 4);
                o = route_ref(h);
                in_q[p].push_back(h);
                exp_q[p][o].push_back(h);
                in_q[p].push_back(16'(n));
                exp_q[p][o].push_back(16'(n));
                for (int i = 0; i < n; i++) begin
                    pl = {4'(p), 4'(k), 8'(i)};
                    in_q[p].push_back(pl);
                    exp_q[p][o].push_back(pl);
                end
            end
        end
        mark();
        cyc = 0;
        pending = 1;
        while (pending != 0 && cyc < 3000) begin
            for (int q = 0; q < NP; q++) credit_i[q] = ($urandom_range(0, 3) != 0);
            step();
            cyc++;
            pending = 0;
            for (int p = 0; p < NP; p++) pending += in_q[p].size();
        end
        vectors++;
        if (pending != 0) begin miscompares++; $display("FAIL rand_inject_timeout got %0d flits left want 0", pending); end
        credit_i = '1;
        run_idle(150);
        for (int oo = 0; oo < NP; oo++) begin
            idx = base[oo];
            while (idx < obs_q[oo].size()) begin
                len = (idx + 1 < obs_q[oo].size()) ? int'(obs_q[oo][idx+1]) + 2 : 2;
                found = 1'b0;
                if (idx + len <= obs_q[oo].size()) begin
                    for (int p = 0; p < NP; p++) begin
                        if (!found && exp_q[p][oo].size() >= len) begin
                            ok = 1'b1;
                            for (int i = 0; i < len; i++)
                                if (exp_q[p][oo][i] !== obs_q[oo][idx+i]) ok = 1'b0;
                            if (ok) begin
                                found = 1'b1;
                                repeat (len) void'(exp_q[p][oo].pop_front());
                            end
                        end
                    end
                end
                vectors++;
                if (!found) begin
                    miscompares++;
                    $display("FAIL rand_pkt out=%0d got header %h len %0d want a whole expected packet", oo, obs_q[oo][idx], len);
                    break;
                end
                idx += len;
            end
        end
        for (int p = 0; p < NP; p++) begin
            for (int oo = 0; oo < NP; oo++) begin
                vectors++;
                if (exp_q[p][oo].size() != 0) begin
                    miscompares++; $display("FAIL rand_missing in=%0d out=%0d got %0d flits undelivered want 0", p, oo, exp_q[p][oo].size());
                end
            end
        end
    endtask

    initial begin
        reset    = 1'b0;
        rx       = '0;
        data_in  = '0;
        credit_i = '1;
        for (int o = 0; o < NP; o++) base[o] = 0;
        @(posedge clock);
        #1;
        test_reset();
        test_single();
        test_routing();
        test_backpressure();
        test_contention();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
